// File: rtl/router_output_arbiter.sv
// Credit-aware round-robin output arbiter for a NoC router port with wormhole packet locking.
// Optional stall counter port (stall_cnt) is built only when ROUTER_OUTARB_STALL_CNT_EN is defined.
module router_output_arbiter #(
  parameter int unsigned NUM_INPUTS   = 5,
  parameter int unsigned CREDIT_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] req_is_tail,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  send_out,
  output logic [$clog2(CREDIT_DEPTH+1)-1:0] credit_count,
  output logic                  locked,
  output logic                  credit_err
`ifdef ROUTER_OUTARB_STALL_CNT_EN
  ,output logic [31:0]          stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(CREDIT_DEPTH+1);
  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic               err_q, err_d;
  logic [NUM_INPUTS-1:0] grant_c;
  logic [IDX_W-1:0]   pick;
  logic               found;
  int                 cand;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (32'(i) == NUM_INPUTS - 1) ? '0 : i + 1'b1;
  endfunction

  // State register: ownership, round-robin pointer, credits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      credit_q <= CNT_W'(CREDIT_DEPTH);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  // Arbitration and next-state; descending scan so the lowest offset from rr_q wins
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_c = '0;
    pick    = rr_q;
    found   = 1'b0;
    cand    = 0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      cand = (int'(rr_q) + k) % int'(NUM_INPUTS);
      if (req[IDX_W'(cand)]) begin
        pick  = IDX_W'(cand);
        found = 1'b1;
      end
    end
    if (rst_n && credit_q != '0) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_c[pick] = 1'b1;
            if (req_is_tail[pick]) begin
              rr_d = wrap_inc(pick);
            end else begin
              state_d = LOCKED;
              owner_d = pick;
            end
          end
        end
        LOCKED: begin
          if (req[owner_q]) begin
            grant_c[owner_q] = 1'b1;
            if (req_is_tail[owner_q]) begin
              state_d = IDLE;
              rr_d    = wrap_inc(owner_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Credit accounting; a return with a full counter is an overflow
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({send_out, credit_in})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CNT_W'(CREDIT_DEPTH)) err_d = 1'b1;
        else                                  credit_d = credit_q + 1'b1;
      end
      default: credit_d = credit_q;
    endcase
  end

  assign grant        = grant_c;
  assign send_out     = |grant_c;
  assign locked       = (state_q == LOCKED);
  assign credit_count = credit_q;
  assign credit_err   = err_q;

`ifdef ROUTER_OUTARB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Cycles where someone wants the output but nothing moves
  always_comb begin
    stall_d = stall_q;
    if (|req && !send_out && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: directed vector table, hand sequences and a random run against a reference model.
module tb_router_output_arbiter;

  localparam int unsigned N = 5;
  localparam int D0 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] req0, tail0, grant0;
  logic         cin0, send0, lock0, err0;
  logic [2:0]   cnt0;
  logic [N-1:0] req1, tail1, grant1;
  logic         cin1, send1, lock1, err1;
  logic [0:0]   cnt1;
`ifdef ROUTER_OUTARB_STALL_CNT_EN
  logic [31:0]  stall0, stall1;
`endif

  router_output_arbiter #(.NUM_INPUTS(N), .CREDIT_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_is_tail(tail0), .credit_in(cin0),
    .grant(grant0), .send_out(send0), .credit_count(cnt0), .locked(lock0), .credit_err(err0)
`ifdef ROUTER_OUTARB_STALL_CNT_EN
    , .stall_cnt(stall0)
`endif
  );

  router_output_arbiter #(.NUM_INPUTS(N), .CREDIT_DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_is_tail(tail1), .credit_in(cin1),
    .grant(grant1), .send_out(send1), .credit_count(cnt1), .locked(lock1), .credit_err(err1)
`ifdef ROUTER_OUTARB_STALL_CNT_EN
    , .stall_cnt(stall1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [4:0] r;
    logic [4:0] t;
    bit         c;
    logic [4:0] eg;
    bit         el;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, logic [4:0] r, logic [4:0] t, bit c,
                              logic [4:0] eg, bit el, int ec);
    vec_t v;
    v.rst = rst; v.r = r; v.t = t; v.c = c; v.eg = eg; v.el = el; v.ec = ec;
    tbl.push_back(v);
  endfunction

  // Reference model: plain integers, owner = -1 when the output is free
  int m_owner, m_rr, m_cred;
  bit m_err;

  function automatic void m_reset();
    m_owner = -1; m_rr = 0; m_cred = D0; m_err = 0;
  endfunction

  function automatic int m_pick(logic [4:0] r);
    if (m_cred == 0) return -1;
    if (m_owner >= 0) return r[m_owner] ? m_owner : -1;
    for (int j = 0; j < int'(N); j++) begin
      if (r[(m_rr + j) % int'(N)]) return (m_rr + j) % int'(N);
    end
    return -1;
  endfunction

  function automatic void m_update(int p, logic [4:0] t, bit c);
    bit sent;
    sent = (p >= 0);
    if (sent) begin
      if (t[p]) begin
        m_owner = -1;
        m_rr    = (p + 1) % int'(N);
      end else begin
        m_owner = p;
      end
    end
    if (sent && !c) m_cred--;
    else if (!sent && c) begin
      if (m_cred == D0) m_err = 1;
      else              m_cred++;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = '1; tail0 = '1; cin0 = 1'b0;
    req1 = '1; tail1 = '1; cin1 = 1'b0;
    #1;
    chk("rst grant", 32'(grant0), 32'd0);
    chk("rst send_out", 32'(send0), 32'd0);
    chk("rst locked", 32'(lock0), 32'd0);
    chk("rst credit_count", 32'(cnt0), 32'd4);
    chk("rst credit_err", 32'(err0), 32'd0);
    chk("rst grant d1", 32'(grant1), 32'd0);
    chk("rst credit_count d1", 32'(cnt1), 32'd1);
    @(negedge clk);
    req0 = '0; tail0 = '0; req1 = '0; tail1 = '0;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic drive0(input logic [4:0] r, input logic [4:0] t, input logic c);
    @(negedge clk);
    req0 = r; tail0 = t; cin0 = c;
    #1;
  endtask

  task automatic drive1(input logic [4:0] r, input logic [4:0] t, input logic c);
    @(negedge clk);
    req1 = r; tail1 = t; cin1 = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] r, t, eg;
    bit c;
    int p;

    rst_n = 1'b1;
    req0 = '0; tail0 = '0; cin0 = 1'b0;
    req1 = '0; tail1 = '0; cin1 = 1'b0;

    // Round robin over inputs 0,2,4 with single-flit packets and credits returned
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 5'b10101, 5'b11111, 1, 5'b00001, 0, 4);
    add(0, 5'b10101, 5'b11111, 1, 5'b00100, 0, 4);
    add(0, 5'b10101, 5'b11111, 1, 5'b10000, 0, 4);
    add(0, 5'b10101, 5'b11111, 1, 5'b00001, 0, 4);
    add(0, 5'b10101, 5'b11111, 1, 5'b00100, 0, 4);
    // Input 1 three-flit packet locks out input 3
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 5'b01010, 5'b01000, 1, 5'b00010, 0, 4);
    add(0, 5'b01010, 5'b01000, 1, 5'b00010, 1, 4);
    add(0, 5'b01010, 5'b01010, 1, 5'b00010, 1, 4);
    add(0, 5'b01000, 5'b01000, 1, 5'b01000, 0, 4);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        drive0(tbl[i].r, tbl[i].t, tbl[i].c);
        chk($sformatf("tbl[%0d] grant", i), 32'(grant0), 32'(tbl[i].eg));
        chk($sformatf("tbl[%0d] send_out", i), 32'(send0), 32'(|tbl[i].eg));
        chk($sformatf("tbl[%0d] locked", i), 32'(lock0), 32'(tbl[i].el));
        tick();
        chk($sformatf("tbl[%0d] credit_count", i), 32'(cnt0), 32'(tbl[i].ec));
      end
    end

    // Credit accounting: simultaneous send+return holds, return at full overflows
    do_reset();
    drive0(5'b00001, 5'b00001, 0); tick(); chk("cred dec1", 32'(cnt0), 32'd3);
    drive0(5'b00001, 5'b00001, 0); tick(); chk("cred dec2", 32'(cnt0), 32'd2);
    drive0(5'b00001, 5'b00001, 1);
    chk("cred both grant", 32'(grant0), 32'b00001);
    tick(); chk("cred both hold", 32'(cnt0), 32'd2);
    drive0(0, 0, 1); tick(); chk("cred inc3", 32'(cnt0), 32'd3);
    drive0(0, 0, 1); tick(); chk("cred inc4", 32'(cnt0), 32'd4);
    chk("cred err before", 32'(err0), 32'd0);
    drive0(0, 0, 1); tick();
    chk("cred overflow count", 32'(cnt0), 32'd4);
    chk("cred overflow err", 32'(err0), 32'd1);
    drive0(0, 0, 0); tick(); chk("cred err sticky", 32'(err0), 32'd1);

    // Owner bubble, then reset mid-packet
    do_reset();
    drive0(5'b00100, 5'b00000, 0);
    chk("bub head grant", 32'(grant0), 32'b00100);
    tick(); chk("bub locked", 32'(lock0), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive0(5'b11011, 5'b11111, 0);
      chk($sformatf("bub%0d grant", k), 32'(grant0), 32'd0);
      tick();
      chk($sformatf("bub%0d locked", k), 32'(lock0), 32'd1);
    end
    drive0(5'b00100, 5'b00000, 0);
    chk("bub resume grant", 32'(grant0), 32'b00100);
    tick(); chk("bub resume count", 32'(cnt0), 32'd2);
    do_reset();
    drive0(5'b11111, 5'b11111, 0);
    chk("post rst grant", 32'(grant0), 32'b00001);
    tick();
    drive0(5'b11111, 5'b11111, 0);
    chk("post rst grant2", 32'(grant0), 32'b00010);
    tick();

    // Credit exhaustion with a single-slot downstream buffer
    do_reset();
    drive1(5'b00001, 5'b00001, 0);
    chk("exh first grant", 32'(grant1), 32'b00001);
    tick(); chk("exh count0", 32'(cnt1), 32'd0);
    for (int k = 0; k < 2; k++) begin
      drive1(5'b00001, 5'b00001, 0);
      chk($sformatf("exh starve%0d", k), 32'(grant1), 32'd0);
      tick();
    end
    drive1(5'b00001, 5'b00001, 1);
    chk("exh pulse grant", 32'(grant1), 32'd0);
    tick(); chk("exh count1", 32'(cnt1), 32'd1);
    drive1(5'b00001, 5'b00001, 0);
    chk("exh regrant", 32'(grant1), 32'b00001);
    tick();

`ifdef ROUTER_OUTARB_STALL_CNT_EN
    do_reset();
    drive1(5'b00001, 5'b00001, 0); tick();
    for (int k = 0; k < 6; k++) begin
      drive1(5'b00001, 5'b00001, 0); tick();
    end
    chk("stall_cnt", stall1, 32'd6);
    drive1(0, 0, 0); tick();
`endif

    // Random traffic against the reference model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = 5'($urandom);
      t = 5'($urandom) | 5'($urandom);
      c = ($urandom_range(0, 1) == 1);
      p = m_pick(r);
      eg = '0;
      if (p >= 0) eg[p] = 1'b1;
      drive0(r, t, c);
      chk("rnd grant", 32'(grant0), 32'(eg));
      chk("rnd send_out", 32'(send0), 32'(p >= 0));
      chk("rnd locked", 32'(lock0), 32'(m_owner >= 0));
      tick();
      m_update(p, t, c);
      chk("rnd credit_count", 32'(cnt0), 32'(m_cred));
      chk("rnd credit_err", 32'(err0), 32'(m_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
